// File: rtl/uart_tx_if.sv
// Byte-side handshake bundle for uart_tx: local logic offers a byte with i_dv,
// and the transmitter reports ready/busy/done back.
interface uart_tx_if;
  logic [7:0] i_data;
  logic       i_dv;
  logic       o_ready;
  logic       o_busy;
  logic       o_done;

  modport master (
    output i_data,
    output i_dv,
    input  o_ready,
    input  o_busy,
    input  o_done
  );

  modport slave (
    input  i_data,
    input  i_dv,
    output o_ready,
    output o_busy,
    output o_done
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 by default (LSB first, 1 or 2 stop bits), back-to-back capable.
// Optional parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  uart_tx_if.slave  bus,
  output logic      o_tx
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  // Stop bit index of the final stop bit; anything but 2 means a single stop bit.
  localparam logic [2:0] STOP_LAST = (STOP_BITS == 2) ? 3'd1 : 3'd0;

  if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_bad_parity_odd
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q,  baud_d;
  logic [2:0]          bit_q,   bit_d;
  logic [7:0]          shift_q, shift_d;
  logic                tx_q,    tx_d;
`ifdef UART_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  logic bit_end;
  logic stop_end;
  logic ready;
  logic accept;

  assign bit_end  = (baud_q == BAUD_LAST);
  // Last clock of the final stop bit: frame is over, a new byte may be taken now.
  assign stop_end = (state_q == S_STOP) && bit_end && (bit_q == STOP_LAST);
  assign ready    = (state_q == S_IDLE) || stop_end;
  assign accept   = bus.i_dv && ready;

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    // tx_d tracks the state being entered so the line changes on the same edge.
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
      end
      S_START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = parity_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        tx_d = parity_q;
        if (bit_end) begin
          state_d = S_STOP;
          bit_d   = 3'd0;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          bit_d = bit_q + 1'b1;
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            bit_d   = 3'd0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (accept) begin
      state_d  = S_START;
      baud_d   = '0;
      bit_d    = 3'd0;
      shift_d  = bus.i_data;
      tx_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d = (PARITY_ODD != 0) ? ~^bus.i_data : ^bus.i_data;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign o_tx        = tx_q;
  assign bus.o_ready = ready;
  assign bus.o_busy  = ~ready;
  assign bus.o_done  = stop_end;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at default parameters (434 clocks per bit, 20 ns clock):
// table of frames plus back-to-back, busy-poke and mid-frame reset sequences.
module tb_uart_tx;

  localparam int CPB   = 434;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic rst_n;
  logic tx;

  uart_tx_if bus();

  uart_tx dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus),
    .o_tx    (tx)
  );

  always #10 clk = ~clk;

  int n_cmp      = 0;
  int n_bad      = 0;
  int done_total = 0;

  always @(negedge clk) if (bus.o_done === 1'b1) done_total++;

  typedef struct {
    logic [7:0] data;
    logic [9:0] exp;   // line bits, index 0 = start bit, index 9 = stop bit
    string      name;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.o_ready !== 1'b1 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10000) chk("ready wait timeout", 32'd0, 32'd1);
  endtask

  // Returns at the negedge of start-bit cycle 0 (the edge after acceptance).
  task automatic send(input logic [7:0] d);
    wait_ready();
    bus.i_data = d;
    bus.i_dv   = 1'b1;
    @(negedge clk);
    bus.i_dv   = 1'b0;
  endtask

  // Entered at the negedge of start-bit cycle 0; leaves at the negedge of the last stop cycle.
  task automatic check_frame(input logic [9:0] exp, input string nm, input int poke_at);
    int   good[10] = '{default: 0};
    int   done_pos = -1;
    int   done_cnt = 0;
    logic rdy_prev = 1'bx;
    logic rdy_last = 1'bx;
    logic busy_last = 1'bx;
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) @(negedge clk);
      if (tx === exp[k / CPB]) good[k / CPB]++;
      if (bus.o_done === 1'b1) begin
        done_cnt++;
        if (done_pos < 0) done_pos = k;
      end
      if (k == FRAME - 2) rdy_prev = bus.o_ready;
      if (k == FRAME - 1) begin
        rdy_last  = bus.o_ready;
        busy_last = bus.o_busy;
      end
      if (poke_at >= 0 && k == poke_at) begin
        bus.i_data = 8'hAA;
        bus.i_dv   = 1'b1;
      end
      if (poke_at >= 0 && k == poke_at + 1) bus.i_dv = 1'b0;
    end
    for (int i = 0; i < 10; i++)
      chk($sformatf("%s bit%0d cycles at level", nm, i), good[i], CPB);
    chk($sformatf("%s done position", nm), done_pos, FRAME - 1);
    chk($sformatf("%s done count", nm), done_cnt, 1);
    chk($sformatf("%s ready before last cycle", nm), {31'd0, rdy_prev}, 32'd0);
    chk($sformatf("%s ready in last cycle", nm), {31'd0, rdy_last}, 32'd1);
    chk($sformatf("%s busy in last cycle", nm), {31'd0, busy_last}, 32'd0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int d0;

    vecs[0] = '{8'h37, 10'b1001101110, "0x37"};
    vecs[1] = '{8'h03, 10'b1000000110, "0x03"};
    vecs[2] = '{8'h00, 10'b1000000000, "0x00"};
    vecs[3] = '{8'hFF, 10'b1111111110, "0xFF"};
    vecs[4] = '{8'hAA, 10'b1101010100, "0xAA"};
    vecs[5] = '{8'h55, 10'b1010101010, "0x55"};

    bus.i_dv   = 1'b0;
    bus.i_data = 8'h00;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset tx",    {31'd0, tx},          32'd1);
    chk("reset ready", {31'd0, bus.o_ready}, 32'd1);
    chk("reset busy",  {31'd0, bus.o_busy},  32'd0);
    chk("reset done",  {31'd0, bus.o_done},  32'd0);
    rst_n = 1'b1;

    // Idle after reset
    bad = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || bus.o_ready !== 1'b1 || bus.o_done !== 1'b0) bad++;
    end
    chk("idle 1000 cycles bad samples", bad, 0);

    // Table of single frames
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].data);
      check_frame(vecs[i].exp, vecs[i].name, -1);
      @(negedge clk);
      chk({vecs[i].name, " idle tx after"},    {31'd0, tx},          32'd1);
      chk({vecs[i].name, " idle ready after"}, {31'd0, bus.o_ready}, 32'd1);
    end

    // Back-to-back: i_dv held high, second byte taken in the o_done cycle
    d0 = done_total;
    @(negedge clk);
    bus.i_data = 8'h37;
    bus.i_dv   = 1'b1;
    @(negedge clk);
    bus.i_data = 8'h03;
    check_frame(vecs[0].exp, "b2b first", -1);
    @(negedge clk);
    bus.i_dv = 1'b0;
    check_frame(vecs[1].exp, "b2b second", -1);
    @(negedge clk);
    chk("b2b idle tx after", {31'd0, tx}, 32'd1);
    chk("b2b done pulses", done_total - d0, 2);

    // Byte offered while busy must be dropped
    send(8'h37);
    check_frame(vecs[0].exp, "poke", 1000);
    bad = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || bus.o_ready !== 1'b1) bad++;
    end
    chk("poke dropped byte idle samples", bad, 0);

    // Reset in the middle of data bit 3 (line bit 4)
    send(8'h37);
    for (int k = 1; k <= 4 * CPB + 200; k++) @(negedge clk);
    chk("pre-reset tx in data bit3", {31'd0, tx}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async reset tx",    {31'd0, tx},          32'd1);
    chk("async reset ready", {31'd0, bus.o_ready}, 32'd1);
    chk("async reset busy",  {31'd0, bus.o_busy},  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < CPB * 2; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || bus.o_ready !== 1'b1) bad++;
    end
    chk("post-reset frame not resumed", bad, 0);
    send(8'h55);
    check_frame(vecs[5].exp, "post-reset 0x55", -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
